// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte over open-drain
// PS2_CLK/PS2_DAT and reports device ACK (done) or failure (error).
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       send_valid,
  input  logic [7:0] send_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int MAXC =
    (TIMEOUT_CYCLES > INHIBIT_CYCLES) ?
    TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SHIFT,
    S_ACK,
    S_WAIT_IDLE
  } state_e;

  state_e        state_q;
  logic [9:0]    shift_q;
  logic [3:0]    idx_q;
  logic [CW-1:0] cnt_q;
  logic          clk_s1_q, clk_s2_q, clk_prev_q;
  logic          dat_s1_q, dat_s2_q;
  logic          clk_oe_q, dat_oe_q;
  logic          busy_q, done_q, error_q;

  logic [CW-1:0] cnt_d;
  logic [9:0]    frame_d;
  logic          fe, tmo, inh_end;
  logic          line_idle, watch, tmo_hit;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk_in;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_dat_in;
      dat_s2_q   <= dat_s1_q;
    end
  end

  always_comb begin
    fe        = clk_prev_q & ~clk_s2_q;
    cnt_d     = cnt_q + 1'b1;
    frame_d   = {1'b1, ~^send_data, send_data};
    tmo       = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    inh_end   = (cnt_q == CW'(INHIBIT_CYCLES - 1));
    line_idle = clk_s2_q & dat_s2_q;
    watch     = (state_q == S_SHIFT) ||
                (state_q == S_ACK) ||
                (state_q == S_WAIT_IDLE);
    tmo_hit   = watch && !fe && tmo &&
                !((state_q == S_WAIT_IDLE) && line_idle);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (send_valid) begin
            shift_q  <= frame_d;
            busy_q   <= 1'b1;
            clk_oe_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (inh_end) begin
            dat_oe_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= S_REQ;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_REQ: begin
          clk_oe_q <= 1'b0;
          idx_q    <= '0;
          cnt_q    <= '0;
          state_q  <= S_SHIFT;
        end
        S_SHIFT: begin
          if (fe) begin
            dat_oe_q <= ~shift_q[idx_q];
            idx_q    <= idx_q + 1'b1;
            cnt_q    <= '0;
            if (idx_q == 4'd9)
              state_q <= S_ACK;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_ACK: begin
          if (fe) begin
            cnt_q <= '0;
            if (!dat_s2_q) begin
              state_q <= S_WAIT_IDLE;
            end else begin
              error_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_WAIT_IDLE: begin
          if (line_idle) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else if (fe) begin
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      // device went silent: drop the lines and give up
      if (tmo_hit) begin
        clk_oe_q <= 1'b0;
        dat_oe_q <= 1'b0;
        error_q  <= 1'b1;
        busy_q   <= 1'b0;
        cnt_q    <= '0;
        state_q  <= S_IDLE;
      end
    end
  end

  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a bus-level PS/2 device model.
module tb_ps2_host_tx;

  localparam int INH = 50;
  localparam int TMO = 1000;
  localparam int H   = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       send_valid = 1'b0;
  logic [7:0] send_data = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       ps2_clk_in, ps2_dat_in;
  logic       clk_oe, dat_oe, busy, done, error;

  int checks = 0;
  int errors = 0;
  int done_n = 0;
  int err_n = 0;
  int oe_n = 0;
  int both_n = 0;
  int busy_bad = 0;

  assign ps2_clk_in = clk_oe ? 1'b0 : dev_clk;
  assign ps2_dat_in = dat_oe ? 1'b0 : dev_dat;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLOCK_50  (clk),
    .reset     (rst),
    .send_valid(send_valid),
    .send_data (send_data),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(clk_oe),
    .ps2_dat_oe(dat_oe),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always @(posedge clk) begin
    if (done)           done_n <= done_n + 1;
    if (error)          err_n  <= err_n + 1;
    if (done && error)  both_n <= both_n + 1;
    if (clk_oe)         oe_n   <= oe_n + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic pulse_send(input logic [7:0] d);
    @(negedge clk);
    send_data  = d;
    send_valid = 1'b1;
    @(negedge clk);
    send_valid = 1'b0;
  endtask

  task automatic dev_xfer(input bit ack,
                          output logic [9:0] rx,
                          output bit ok);
    int t;
    t  = 0;
    rx = '0;
    ok = 1'b1;
    while (!(clk_oe === 1'b0 && dat_oe === 1'b1) &&
           t < INH + 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= INH + 100) begin
      ok = 1'b0;
      return;
    end
    repeat (H) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      if (busy !== 1'b1) busy_bad++;
      rx[i] = ps2_dat_in;
      dev_clk = 1'b1;
      repeat (H) @(negedge clk);
    end
    dev_dat = ack ? 1'b0 : 1'b1;
    repeat (4) @(negedge clk);
    dev_clk = 1'b0;
    repeat (H) @(negedge clk);
    dev_clk = 1'b1;
    repeat (H) @(negedge clk);
    dev_dat = 1'b1;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({clk_oe, dat_oe, busy, done, error} !== 5'b0) begin
      errors++;
      $display("FAIL reset_hold: got %b want 00000",
               {clk_oe, dat_oe, busy, done, error});
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ({clk_oe, dat_oe, busy, done, error} !== 5'b0) begin
      errors++;
      $display("FAIL reset_idle: got %b want 00000",
               {clk_oe, dat_oe, busy, done, error});
    end
  endtask

  task automatic wait_done(input int d0);
    int t;
    t = 0;
    while (done_n == d0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_send(input logic [7:0] d,
                           input logic [9:0] exp,
                           input string name);
    logic [9:0] rx;
    bit ok;
    int d0, e0, o0, b0;
    d0 = done_n; e0 = err_n; o0 = oe_n; b0 = busy_bad;
    pulse_send(d);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy_accept: got %b want 1", name, busy);
    end
    dev_xfer(1'b1, rx, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_request: got none want request", name);
    end
    wait_done(d0);
    checks++;
    if (rx !== exp) begin
      errors++;
      $display("FAIL %s_frame: got %h want %h", name, rx, exp);
    end
    checks++;
    if (done_n - d0 != 1) begin
      errors++;
      $display("FAIL %s_done: got %0d want 1", name, done_n - d0);
    end
    checks++;
    if (err_n != e0) begin
      errors++;
      $display("FAIL %s_error: got %0d want 0", name, err_n - e0);
    end
    checks++;
    if (oe_n - o0 != INH + 1) begin
      errors++;
      $display("FAIL %s_inhibit: got %0d want %0d",
               name, oe_n - o0, INH + 1);
    end
    checks++;
    if (busy !== 1'b0 || busy_bad != b0) begin
      errors++;
      $display("FAIL %s_busy_span: got busy=%b drops=%0d want 0 0",
               name, busy, busy_bad - b0);
    end
  endtask

  task automatic test_timeout;
    int d0, e0, t, n;
    d0 = done_n; e0 = err_n;
    pulse_send(8'h12);
    t = 0;
    while (!(clk_oe === 1'b1 && dat_oe === 1'b1) && t < INH + 20) begin
      @(negedge clk);
      t++;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (error !== 1'b1 && n < TMO + 50);
    checks++;
    if (n != TMO + 1) begin
      errors++;
      $display("FAIL tmo_latency: got %0d want %0d", n, TMO + 1);
    end
    checks++;
    if ({clk_oe, dat_oe, busy} !== 3'b000) begin
      errors++;
      $display("FAIL tmo_release: got %b want 000",
               {clk_oe, dat_oe, busy});
    end
    @(negedge clk);
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL tmo_pulse_width: got %b want 0", error);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_n != d0 || err_n - e0 != 1) begin
      errors++;
      $display("FAIL tmo_counts: got done=%0d err=%0d want 0 1",
               done_n - d0, err_n - e0);
    end
  endtask

  task automatic test_no_ack;
    logic [9:0] rx;
    bit ok;
    int d0, e0;
    d0 = done_n; e0 = err_n;
    pulse_send(8'hA5);
    dev_xfer(1'b0, rx, ok);
    repeat (5) @(negedge clk);
    checks++;
    if (rx !== 10'h3A5) begin
      errors++;
      $display("FAIL nak_frame: got %h want 3a5", rx);
    end
    checks++;
    if (done_n != d0 || err_n - e0 != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL nak_result: got done=%0d err=%0d busy=%b want 0 1 0",
               done_n - d0, err_n - e0, busy);
    end
    test_send(8'hFF, 10'h3FF, "ff_after_nak");
  endtask

  task automatic test_ignore;
    logic [9:0] rx;
    bit ok;
    int d0, o0;
    d0 = done_n; o0 = oe_n;
    pulse_send(8'hED);
    fork
      dev_xfer(1'b1, rx, ok);
      begin
        repeat (300) @(negedge clk);
        send_data  = 8'h55;
        send_valid = 1'b1;
        @(negedge clk);
        send_valid = 1'b0;
      end
    join
    wait_done(d0);
    repeat (INH + 30) @(negedge clk);
    checks++;
    if (rx !== 10'h3ED) begin
      errors++;
      $display("FAIL ignore_frame: got %h want 3ed", rx);
    end
    checks++;
    if (done_n - d0 != 1 || oe_n - o0 != INH + 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_queue: got done=%0d oe=%0d busy=%b want 1 %0d 0",
               done_n - d0, oe_n - o0, busy, INH + 1);
    end
  endtask

  task automatic test_reset_mid;
    int d0, e0, t;
    d0 = done_n; e0 = err_n;
    pulse_send(8'h30);
    t = 0;
    while (!(clk_oe === 1'b0 && dat_oe === 1'b1) && t < INH + 100) begin
      @(negedge clk);
      t++;
    end
    repeat (H) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      dev_clk = 1'b1;
      repeat (H) @(negedge clk);
    end
    checks++;
    if (dat_oe !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: got dat_oe=%b busy=%b want 1 1",
               dat_oe, busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({clk_oe, dat_oe, busy} !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid_async: got %b want 000",
               {clk_oe, dat_oe, busy});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (done_n != d0 || err_n != e0) begin
      errors++;
      $display("FAIL rst_mid_pulses: got done=%0d err=%0d want 0 0",
               done_n - d0, err_n - e0);
    end
  endtask

  initial begin
    test_reset();
    test_send(8'hED, 10'h3ED, "ed");
    test_send(8'h07, 10'h207, "x07");
    test_timeout();
    test_no_ack();
    test_ignore();
    test_reset_mid();
    test_send(8'h00, 10'h300, "x00_after_rst");
    checks++;
    if (both_n != 0) begin
      errors++;
      $display("FAIL done_and_error: got %0d want 0", both_n);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
